// File: rtl/mem_arbiter_if.sv
// Requester and backing-memory signal bundle for mem_arbiter.
// master = requesters plus memory model side, slave = the arbiter.
interface mem_arbiter_if;
  logic        ReqRead0, ReqRead1;
  logic        ReqWrite0, ReqWrite1;
  logic [31:0] ReqAddress0, ReqAddress1;
  logic [31:0] ReqWriteData0, ReqWriteData1;
  logic [31:0] ReqData0, ReqData1;
  logic        ReqValid0, ReqValid1;
  logic        ReqErr0, ReqErr1;
  logic        MemRead, MemWrite;
  logic [31:0] MemAddress, MemWriteData;
  logic [31:0] MemData;
  logic        MemValid;

  modport master (
    output ReqRead0, ReqRead1, ReqWrite0, ReqWrite1,
    output ReqAddress0, ReqAddress1, ReqWriteData0, ReqWriteData1,
    output MemData, MemValid,
    input  ReqData0, ReqData1, ReqValid0, ReqValid1, ReqErr0, ReqErr1,
    input  MemRead, MemWrite, MemAddress, MemWriteData
  );

  modport slave (
    input  ReqRead0, ReqRead1, ReqWrite0, ReqWrite1,
    input  ReqAddress0, ReqAddress1, ReqWriteData0, ReqWriteData1,
    input  MemData, MemValid,
    output ReqData0, ReqData1, ReqValid0, ReqValid1, ReqErr0, ReqErr1,
    output MemRead, MemWrite, MemAddress, MemWriteData
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter onto a single backing memory,
// with a per-transaction wait timeout that aborts with an error pulse.
module mem_arbiter #(
  parameter int unsigned TIMEOUT   = 255,
  parameter bit          INIT_PRIO = 1'b0
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;

  // Terminal BUSY cycle is the one whose increment would hit TIMEOUT.
  localparam logic [15:0] TERM = 16'(TIMEOUT - 1);

  state_t      state;
  logic        win, last, op_wr;
  logic [31:0] addr_q, wdata_q;
  logic [15:0] wait_cnt;

  logic pend0, pend1, arb_win, busy, done, abort;

  assign pend0   = bus.ReqRead0 | bus.ReqWrite0;
  assign pend1   = bus.ReqRead1 | bus.ReqWrite1;
  assign arb_win = (pend0 && pend1) ? ~last : pend1;
  assign busy    = (state == BUSY);
  assign done    = busy && bus.MemValid;
  assign abort   = busy && !bus.MemValid && (wait_cnt == TERM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      win      <= 1'b0;
      last     <= ~INIT_PRIO;
      op_wr    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (pend0 || pend1) begin
          state    <= BUSY;
          win      <= arb_win;
          op_wr    <= arb_win ? bus.ReqWrite1 : bus.ReqWrite0;
          addr_q   <= arb_win ? bus.ReqAddress1 : bus.ReqAddress0;
          wdata_q  <= arb_win ? bus.ReqWriteData1 : bus.ReqWriteData0;
          wait_cnt <= '0;
        end
        BUSY: if (done || abort) begin
          state <= IDLE;
          last  <= win;
        end else begin
          wait_cnt <= wait_cnt + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes derive from the async-reset state, so they drop as soon as rst rises.
  assign bus.MemRead      = busy & ~op_wr;
  assign bus.MemWrite     = busy &  op_wr;
  assign bus.MemAddress   = addr_q;
  assign bus.MemWriteData = wdata_q;

  assign bus.ReqValid0 = done & ~win;
  assign bus.ReqValid1 = done &  win;
  assign bus.ReqErr0   = abort & ~win;
  assign bus.ReqErr1   = abort &  win;
  assign bus.ReqData0  = bus.ReqValid0 ? bus.MemData : 32'h0;
  assign bus.ReqData1  = bus.ReqValid1 ? bus.MemData : 32'h0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions push expected
// completions; a negedge monitor pops and checks every ReqValid/ReqErr pulse.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus();
  mem_arbiter #(.TIMEOUT(4), .INIT_PRIO(1'b0)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {int idx; bit err; logic [31:0] data;} exp_t;
  exp_t sb[$];
  int   stamps[$];
  int   checks = 0, fails = 0, cyc = 0, nev = 0, resp_at = 0, bcnt = 0;
  bit   mv_force = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEADBEEF : (a ^ 32'hA5A5_0000);
  endfunction

  // Memory model: answers on the resp_at-th BUSY cycle (0 = never).
  always @(posedge clk) begin
    cyc++;
    #1;
    if (bus.MemRead || bus.MemWrite) bcnt++;
    else bcnt = 0;
    bus.MemValid = mv_force || (resp_at != 0 && bcnt == resp_at);
    bus.MemData  = bus.MemValid ? mem_fn(bus.MemAddress) : 32'h0;
  end

  always @(negedge clk) begin : mon
    logic [3:0] o;
    exp_t e;
    if (!rst) begin
      o = {bus.ReqErr1, bus.ReqErr0, bus.ReqValid1, bus.ReqValid0};
      chk("onehot_outputs", {31'b0, ($countones(o) > 1)}, 32'h0);
      if (!bus.ReqValid0) chk("data0_zero", bus.ReqData0, 32'h0);
      if (!bus.ReqValid1) chk("data1_zero", bus.ReqData1, 32'h0);
      if (o != 4'b0) begin
        nev++;
        stamps.push_back(cyc);
        if (sb.size() == 0) begin
          chk("unexpected_pulse", {28'b0, o}, 32'h0);
        end else begin
          e = sb.pop_front();
          chk("evt_idx", {31'b0, bus.ReqValid1 | bus.ReqErr1}, e.idx);
          chk("evt_err", {31'b0, bus.ReqErr0 | bus.ReqErr1}, {31'b0, e.err});
          chk("evt_data", bus.ReqValid1 ? bus.ReqData1 : bus.ReqData0, e.data);
        end
      end
    end
  end

  task automatic set_req(input int idx, input bit rd, input bit wr,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (idx == 0) begin
      bus.ReqRead0 = rd; bus.ReqWrite0 = wr; bus.ReqAddress0 = addr; bus.ReqWriteData0 = wdata;
    end else begin
      bus.ReqRead1 = rd; bus.ReqWrite1 = wr; bus.ReqAddress1 = addr; bus.ReqWriteData1 = wdata;
    end
  endtask

  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(posedge clk); #2;
      ok = bus.MemRead | bus.MemWrite;
    end
  endtask

  // One transaction; request is scrambled once granted to prove the latched copy is used.
  task automatic txn(input int idx, input bit rd, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input int resp, input int lat, input bit err);
    int g;
    bit ok;
    @(negedge clk); #1;
    resp_at = resp;
    set_req(idx, rd, wr, addr, wdata);
    sb.push_back('{idx, err, err ? 32'h0 : mem_fn(addr)});
    wait_busy(ok);
    chk("grant", {31'b0, ok}, 32'h1);
    g = cyc;
    set_req(idx, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      chk("mem_addr_hold", bus.MemAddress, addr);
      chk("mem_wdata_hold", bus.MemWriteData, wdata);
      chk("mem_write", {31'b0, bus.MemWrite}, {31'b0, wr});
      chk("mem_read", {31'b0, bus.MemRead}, {31'b0, rd & ~wr});
      @(posedge clk); #2;
      ok = !(bus.MemRead || bus.MemWrite);
    end
    chk("back_to_idle", {31'b0, ok}, 32'h1);
    chk("latency", (stamps.size() != 0) ? stamps[$] - g : -1, lat);
  endtask

  initial begin
    int base;
    bit ok;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.MemValid = 1'b0;
    bus.MemData  = 32'h0;

    // Held in reset, even with a request pending.
    bus.ReqRead0 = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_memread", {31'b0, bus.MemRead}, 32'h0);
    chk("rst_memwrite", {31'b0, bus.MemWrite}, 32'h0);
    chk("rst_memaddr", bus.MemAddress, 32'h0);
    chk("rst_outputs", {28'b0, bus.ReqValid0, bus.ReqValid1, bus.ReqErr0, bus.ReqErr1}, 32'h0);
    chk("rst_data", bus.ReqData0 | bus.ReqData1, 32'h0);
    bus.ReqRead0 = 1'b0;
    @(negedge clk); rst = 1'b0;

    // Single read from requester 1.
    txn(1, 1'b1, 1'b0, 32'h40, 32'h0, 2, 1, 1'b0);

    // Contention: both pending continuously, answer on 2nd BUSY cycle.
    @(negedge clk); #1;
    resp_at = 2;
    set_req(0, 1'b1, 1'b0, 32'h100, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h200, 32'h0);
    sb.push_back('{0, 1'b0, mem_fn(32'h100)});
    sb.push_back('{1, 1'b0, mem_fn(32'h200)});
    sb.push_back('{0, 1'b0, mem_fn(32'h100)});
    sb.push_back('{1, 1'b0, mem_fn(32'h200)});
    base = nev;
    for (int i = 0; i < 40 && nev < base + 4; i++) begin
      @(negedge clk); #1;
    end
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("contention_count", nev - base, 4);
    for (int k = 1; k < 4; k++)
      chk("contention_spacing",
          (stamps.size() >= base + 4) ? stamps[base + k] - stamps[base + k - 1] : -1, 3);
    repeat (2) @(posedge clk);

    // Write wins over read; address/data held despite input changes.
    txn(0, 1'b1, 1'b1, 32'h300, 32'h1234_5678, 3, 2, 1'b0);
    // MemValid in the terminal cycle: completion wins.
    txn(1, 1'b1, 1'b0, 32'h500, 32'h0, 4, 3, 1'b0);
    // No MemValid: error after 4 BUSY cycles.
    txn(1, 1'b1, 1'b0, 32'h600, 32'h0, 0, 3, 1'b1);
    // Requester 0 served normally after the abort.
    txn(0, 1'b1, 1'b0, 32'h700, 32'h0, 2, 1, 1'b0);

    // Stray MemValid in IDLE does nothing.
    @(negedge clk); #1; mv_force = 1'b1;
    @(posedge clk); #2;
    chk("idle_mv_valid", {31'b0, bus.MemValid}, 32'h1);
    chk("idle_mv_noread", {31'b0, bus.MemRead | bus.MemWrite}, 32'h0);
    @(negedge clk); #1; mv_force = 1'b0;
    @(posedge clk); #2;
    chk("idle_mv_stay_idle", {31'b0, bus.MemRead | bus.MemWrite}, 32'h0);

    // Reset mid-transaction; last served is 0 so only reset makes 0 win next.
    @(negedge clk); #1;
    resp_at = 0;
    set_req(1, 1'b1, 1'b0, 32'h800, 32'h0);
    wait_busy(ok);
    chk("rst_txn_grant", {31'b0, ok}, 32'h1);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("async_rst_memread", {31'b0, bus.MemRead}, 32'h0);
    chk("async_rst_memwrite", {31'b0, bus.MemWrite}, 32'h0);
    chk("async_rst_outputs", {28'b0, bus.ReqValid0, bus.ReqValid1, bus.ReqErr0, bus.ReqErr1}, 32'h0);
    set_req(0, 1'b1, 1'b0, 32'h900, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'hA00, 32'h0);
    resp_at = 2;
    sb.push_back('{0, 1'b0, mem_fn(32'h900)});
    @(negedge clk); #1;
    rst = 1'b0;
    wait_busy(ok);
    chk("post_rst_grant", {31'b0, ok}, 32'h1);
    chk("post_rst_addr", bus.MemAddress, 32'h900);
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(posedge clk); #2;
      ok = !(bus.MemRead || bus.MemWrite);
    end
    chk("post_rst_idle", {31'b0, ok}, 32'h1);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
